// File: rtl/mem_req_queue_if.sv
// L2-side request/response bundle for mem_req_queue.
// master = L2 arbiter side, slave = queue side.
interface mem_req_queue_if;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 128;

  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic          req_rden;
  logic          req_wren;
  logic          req_client_id;
  logic          req_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_valid;
  logic          rsp_client_id;

  modport master (
    output req_addr, req_data, req_rden, req_wren, req_client_id,
    input  req_ready, rsp_data, rsp_valid, rsp_client_id
  );

  modport slave (
    input  req_addr, req_data, req_rden, req_wren, req_client_id,
    output req_ready, rsp_data, rsp_valid, rsp_client_id
  );
endinterface

// File: rtl/mem_req_queue.sv
// FIFO-buffered L2 request queue issuing one memory op at a time, blocking on reads.
// Optional WAIT watchdog enabled by defining MEMQ_TIMEOUT_EN.
module mem_req_queue #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_req_queue_if.slave       l2,
  output logic [31:0]          o_mem_addr,
  output logic [127:0]         o_mem_wdata,
  output logic                 o_mem_rden,
  output logic                 o_mem_wren,
  output logic                 o_mem_client_id,
  output logic                 o_mem_en,
  input  logic [127:0]         i_mem_rdata,
  input  logic                 i_mem_rvalid,
  input  logic                 i_mem_rclient_id,
  output logic [2:0]           o_err
);
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 128;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic          wr;
    logic          rd;
    logic          client;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t        r_state;
  state_t        w_next_state;
  entry_t        r_fifo [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;
  logic          r_ready;
  logic          r_mem_en;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic          r_mem_rden;
  logic          r_mem_wren;
  logic          r_mem_client;
  logic [DW-1:0] r_rsp_data;
  logic          r_rsp_valid;
  logic          r_rsp_client;
  logic [2:0]    r_err;

  logic          w_req;
  logic          w_push;
  logic          w_pop;
  logic          w_capture;
  logic          w_force;
  logic          w_to_hit;
  logic          w_spurious;
  entry_t        w_new;
  entry_t        w_head;

  assign w_req       = l2.req_rden | l2.req_wren;
  assign w_push      = w_req & r_ready;
  assign w_spurious  = i_mem_rvalid & (r_state != S_WAIT);
  assign w_head      = r_fifo[r_rd_ptr];
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

  // A simultaneous rd+wr request is demoted to a write
  assign w_new.wr     = l2.req_wren;
  assign w_new.rd     = l2.req_rden & ~l2.req_wren;
  assign w_new.client = l2.req_client_id;
  assign w_new.addr   = l2.req_addr;
  assign w_new.data   = l2.req_data;

`ifdef MEMQ_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_wait_cnt;

  always_ff @(posedge clk) begin
    if (reset)                 r_wait_cnt <= '0;
    else if (r_state == S_WAIT) r_wait_cnt <= r_wait_cnt + TW'(1);
    else                       r_wait_cnt <= '0;
  end

  assign w_to_hit = (r_state == S_WAIT) && (r_wait_cnt == TW'(TIMEOUT - 1));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 0);
  assign w_to_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_capture    = 1'b0;
    w_force      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_pop        = 1'b1;
          w_next_state = S_ISSUE;
        end
      end
      S_ISSUE: w_next_state = r_mem_rden ? S_WAIT : S_IDLE;
      S_WAIT: begin
        if (i_mem_rvalid) begin
          w_capture    = 1'b1;
          w_next_state = S_IDLE;
        end else if (w_to_hit) begin
          w_force      = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Entry storage carries no reset; validity is tracked by the pointers/count
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_new;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_ready      <= 1'b1;
      r_mem_en     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_rden   <= 1'b0;
      r_mem_wren   <= 1'b0;
      r_mem_client <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_client <= 1'b0;
      r_err        <= '0;
    end else begin
      r_mem_en <= 1'b1;
      r_count  <= w_count_nxt;
      r_ready  <= (w_count_nxt != CW'(DEPTH));
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop) begin
        r_rd_ptr     <= r_rd_ptr + PW'(1);
        r_mem_addr   <= w_head.addr;
        r_mem_wdata  <= w_head.data;
        r_mem_client <= w_head.client;
      end
      // Strobes are only ever high for the single ISSUE cycle
      r_mem_rden  <= w_pop & w_head.rd;
      r_mem_wren  <= w_pop & w_head.wr;
      r_rsp_valid <= w_capture | w_force;
      if (w_capture) begin
        r_rsp_data   <= i_mem_rdata;
        r_rsp_client <= i_mem_rclient_id;
      end else if (w_force) begin
        r_rsp_data   <= '0;
        r_rsp_client <= r_mem_client;
      end
      r_err <= r_err | {w_spurious | w_force,
                        l2.req_rden & l2.req_wren,
                        w_req & ~r_ready};
    end
  end

  assign l2.req_ready     = r_ready;
  assign l2.rsp_data      = r_rsp_data;
  assign l2.rsp_valid     = r_rsp_valid;
  assign l2.rsp_client_id = r_rsp_client;
  assign o_mem_addr       = r_mem_addr;
  assign o_mem_wdata      = r_mem_wdata;
  assign o_mem_rden       = r_mem_rden;
  assign o_mem_wren       = r_mem_wren;
  assign o_mem_client_id  = r_mem_client;
  assign o_mem_en         = r_mem_en;
  assign o_err            = r_err;
endmodule

// File: tb/tb_mem_req_queue.sv
// Scoreboard bench for mem_req_queue with a delayed-response memory model.
// Define MEMQ_TIMEOUT_EN to also exercise the WAIT watchdog.
module tb_mem_req_queue;
  logic         clk;
  logic         reset;
  logic [31:0]  o_mem_addr;
  logic [127:0] o_mem_wdata;
  logic         o_mem_rden;
  logic         o_mem_wren;
  logic         o_mem_client_id;
  logic         o_mem_en;
  logic [127:0] i_mem_rdata;
  logic         i_mem_rvalid;
  logic         i_mem_rclient_id;
  logic [2:0]   o_err;

  mem_req_queue_if l2_if();

  mem_req_queue #(.DEPTH(4), .TIMEOUT(8)) dut (
    .clk              (clk),
    .reset            (reset),
    .l2               (l2_if),
    .o_mem_addr       (o_mem_addr),
    .o_mem_wdata      (o_mem_wdata),
    .o_mem_rden       (o_mem_rden),
    .o_mem_wren       (o_mem_wren),
    .o_mem_client_id  (o_mem_client_id),
    .o_mem_en         (o_mem_en),
    .i_mem_rdata      (i_mem_rdata),
    .i_mem_rvalid     (i_mem_rvalid),
    .i_mem_rclient_id (i_mem_rclient_id),
    .o_err            (o_err)
  );

  typedef struct packed {
    logic         wr;
    logic         rd;
    logic         cl;
    logic [31:0]  addr;
    logic [127:0] data;
  } iss_t;

  typedef struct packed {
    logic         cl;
    logic [127:0] data;
  } rsp_t;

  iss_t exp_iss[$];
  rsp_t exp_rsp[$];
  int   vectors;
  int   miscompares;
  int   mem_delay;
  bit   mem_respond;
  int   spur_req;
  logic [127:0] wd [4];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "simulation time limit reached");
  end

  task automatic chk(input string name, input logic [175:0] act, input logic [175:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: got unexpected event want none", name);
  endtask

  // Drive one request for one clock edge; returns at the following negedge
  task automatic req(input logic rd, input logic wr, input logic cl,
                     input logic [31:0] a, input logic [127:0] d);
    l2_if.req_rden      = rd;
    l2_if.req_wren      = wr;
    l2_if.req_client_id = cl;
    l2_if.req_addr      = a;
    l2_if.req_data      = d;
    @(negedge clk);
    l2_if.req_rden = 1'b0;
    l2_if.req_wren = 1'b0;
  endtask

  task automatic exp_issue(input logic wr, input logic rd, input logic cl,
                           input logic [31:0] a, input logic [127:0] d);
    iss_t e;
    e.wr = wr; e.rd = rd; e.cl = cl; e.addr = a; e.data = d;
    exp_iss.push_back(e);
  endtask

  task automatic exp_resp(input logic cl, input logic [127:0] d);
    rsp_t e;
    e.cl = cl; e.data = d;
    exp_rsp.push_back(e);
  endtask

  task automatic drain(input int budget, input string name);
    int n;
    n = 0;
    while ((exp_iss.size() != 0 || exp_rsp.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (exp_iss.size() != 0 || exp_rsp.size() != 0) begin
      miscompares++;
      $display("FAIL %s: got %0d issues %0d rsps outstanding want 0 0", name,
               exp_iss.size(), exp_rsp.size());
    end
    repeat (3) @(negedge clk);
  endtask

  // Memory model: answers a read with ~addr replicated after mem_delay cycles
  initial begin
    logic [31:0] a;
    logic        c;
    bit          ab;
    int          spur_seen;
    spur_seen        = 0;
    i_mem_rvalid     = 1'b0;
    i_mem_rdata      = '0;
    i_mem_rclient_id = 1'b0;
    forever begin
      @(negedge clk);
      if (spur_req != spur_seen) begin
        spur_seen        = spur_req;
        i_mem_rvalid     = 1'b1;
        i_mem_rdata      = {4{32'hDEAD_BEEF}};
        i_mem_rclient_id = 1'b1;
        @(negedge clk);
        i_mem_rvalid = 1'b0;
      end else if (o_mem_rden && mem_respond && !reset) begin
        a  = o_mem_addr;
        c  = o_mem_client_id;
        ab = 1'b0;
        for (int k = 0; k < mem_delay; k++) begin
          @(negedge clk);
          if (reset) ab = 1'b1;
        end
        if (!ab) begin
          i_mem_rvalid     = 1'b1;
          i_mem_rdata      = {4{~a}};
          i_mem_rclient_id = c;
          @(negedge clk);
          i_mem_rvalid = 1'b0;
        end
      end
    end
  end

  // Monitor: every memory strobe and response pulse is matched against the scoreboard
  initial begin
    iss_t ei;
    rsp_t er;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (o_mem_rden || o_mem_wren) begin
          if (exp_iss.size() == 0) fail_evt("unexpected_issue");
          else begin
            ei = exp_iss.pop_front();
            chk("issue", 176'({o_mem_wren, o_mem_rden, o_mem_client_id, o_mem_addr, o_mem_wdata}),
                176'(ei));
          end
        end
        if (l2_if.rsp_valid) begin
          if (exp_rsp.size() == 0) fail_evt("unexpected_rsp");
          else begin
            er = exp_rsp.pop_front();
            chk("rsp", 176'({l2_if.rsp_client_id, l2_if.rsp_data}), 176'(er));
          end
        end
      end
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    mem_delay   = 5;
    mem_respond = 1'b1;
    spur_req    = 0;
    wd[0] = 128'h0000_0001_0000_0002_0000_0003_0000_0004;
    wd[1] = 128'h1111_1111_2222_2222_3333_3333_4444_4444;
    wd[2] = 128'hA5A5_A5A5_5A5A_5A5A_A5A5_A5A5_5A5A_5A5A;
    wd[3] = 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000;
    l2_if.req_rden      = 1'b0;
    l2_if.req_wren      = 1'b0;
    l2_if.req_client_id = 1'b0;
    l2_if.req_addr      = '0;
    l2_if.req_data      = '0;
    reset = 1'b1;

    // 1: reset values
    repeat (3) @(negedge clk);
    chk("rst_ready",  176'(l2_if.req_ready), 176'(1));
    chk("rst_mem_en", 176'(o_mem_en), 176'(0));
    chk("rst_err",    176'(o_err), 176'(0));
    chk("rst_outs",   176'({l2_if.rsp_valid, l2_if.rsp_data, o_mem_rden, o_mem_wren, o_mem_addr}), 176'(0));
    reset = 1'b0;
    @(negedge clk);
    chk("mem_en_up", 176'(o_mem_en), 176'(1));
    chk("idle_ready", 176'(l2_if.req_ready), 176'(1));

    // 2: single read, client 1, delay 5
    mem_delay = 5;
    exp_issue(1'b0, 1'b1, 1'b1, 32'h100, 128'h0);
    exp_resp(1'b1, 128'hFFFFFEFF_FFFFFEFF_FFFFFEFF_FFFFFEFF);
    req(1'b1, 1'b0, 1'b1, 32'h100, 128'h0);
    chk("rd_not_early", 176'(o_mem_rden), 176'(0));
    @(negedge clk);
    chk("rd_latency", 176'(o_mem_rden), 176'(1));
    drain(40, "drain_read");

    // 3: fill the FIFO behind a slow read, then overflow
    mem_delay = 20;
    exp_issue(1'b0, 1'b1, 1'b0, 32'h180, 128'h0);
    exp_resp(1'b0, 128'hFFFFFE7F_FFFFFE7F_FFFFFE7F_FFFFFE7F);
    req(1'b1, 1'b0, 1'b0, 32'h180, 128'h0);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) chk("ready_before_full", 176'(l2_if.req_ready), 176'(1));
      exp_issue(1'b1, 1'b0, 1'(i), 32'h1000 + 32'(i) * 32'h10, wd[i]);
      req(1'b0, 1'b1, 1'(i), 32'h1000 + 32'(i) * 32'h10, wd[i]);
    end
    chk("ready_full", 176'(l2_if.req_ready), 176'(0));
    l2_if.req_wren      = 1'b1;
    l2_if.req_addr      = 32'h1F00;
    l2_if.req_data      = 128'hBAD;
    l2_if.req_client_id = 1'b0;
    repeat (5) @(negedge clk);
    l2_if.req_wren = 1'b0;
    chk("ready_held_full", 176'(l2_if.req_ready), 176'(0));
    chk("err_overflow", 176'(o_err), 176'(3'b001));
    drain(100, "drain_fill");
    chk("ready_after_drain", 176'(l2_if.req_ready), 176'(1));

    // 4: write then read in consecutive cycles, then rd+wr conflict
    mem_delay = 3;
    exp_issue(1'b1, 1'b0, 1'b0, 32'h200, 128'h2222_0000_2222_0000_2222_0000_2222_0000);
    exp_issue(1'b0, 1'b1, 1'b1, 32'h300, 128'h0);
    exp_resp(1'b1, 128'hFFFFFCFF_FFFFFCFF_FFFFFCFF_FFFFFCFF);
    req(1'b0, 1'b1, 1'b0, 32'h200, 128'h2222_0000_2222_0000_2222_0000_2222_0000);
    req(1'b1, 1'b0, 1'b1, 32'h300, 128'h0);
    drain(40, "drain_wr_rd");
    exp_issue(1'b1, 1'b0, 1'b1, 32'h400, 128'hCAFE);
    req(1'b1, 1'b1, 1'b1, 32'h400, 128'hCAFE);
    chk("err_rw_conflict", 176'(o_err), 176'(3'b011));
    drain(20, "drain_conflict");

    // 5: spurious response while idle, then reset during WAIT
    spur_req++;
    repeat (4) @(negedge clk);
    chk("err_spurious", 176'(o_err), 176'(3'b111));
    mem_delay = 10;
    exp_issue(1'b0, 1'b1, 1'b1, 32'h700, 128'h0);
    req(1'b1, 1'b0, 1'b1, 32'h700, 128'h0);
    repeat (4) @(negedge clk);
    chk("in_wait", 176'(dut.r_state), 176'(2));
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_rst_err",   176'(o_err), 176'(0));
    chk("mid_rst_state", 176'(dut.r_state), 176'(0));
    chk("mid_rst_count", 176'(dut.r_count), 176'(0));
    chk("mid_rst_mem_en", 176'(o_mem_en), 176'(0));
    reset = 1'b0;
    repeat (15) @(negedge clk);
    chk("post_rst_err", 176'(o_err), 176'(0));
    chk("post_rst_ready", 176'(l2_if.req_ready), 176'(1));

    // Normal read after mid-operation reset
    mem_delay = 2;
    exp_issue(1'b0, 1'b1, 1'b0, 32'h40, 128'h0);
    exp_resp(1'b0, 128'hFFFFFFBF_FFFFFFBF_FFFFFFBF_FFFFFFBF);
    req(1'b1, 1'b0, 1'b0, 32'h40, 128'h0);
    drain(30, "drain_post_rst");

`ifdef MEMQ_TIMEOUT_EN
    // 6: memory never answers; forced zero response, then the queued write issues
    mem_respond = 1'b0;
    exp_issue(1'b0, 1'b1, 1'b1, 32'h500, 128'h0);
    exp_resp(1'b1, 128'h0);
    exp_issue(1'b1, 1'b0, 1'b0, 32'h600, 128'h6);
    req(1'b1, 1'b0, 1'b1, 32'h500, 128'h0);
    req(1'b0, 1'b1, 1'b0, 32'h600, 128'h6);
    drain(60, "drain_timeout");
    chk("err_timeout", 176'(o_err[2]), 176'(1));
    mem_respond = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
